// File: rtl/tau_stack_pkg.sv
// Shared definitions for the tau processor's return-address stack:
// the four stack operations and the push/pop decode.
package tau_stack_pkg;

    typedef enum logic [1:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_REPLACE
    } stack_op_t;

    function automatic stack_op_t stk_decode(input logic push, input logic pop);
        unique case ({push, pop})
            2'b10:   return STK_PUSH;
            2'b01:   return STK_POP;
            2'b11:   return STK_REPLACE;
            default: return STK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/call_stack_if.sv
// Request/response and status signals between the core and the call stack.
// master = core side (requests), slave = stack side.
interface call_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic             enable;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_value;
    logic [WIDTH-1:0] pop_value;
    logic             load_valid;
    logic [PTR_W-1:0] depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output enable, push, pop, push_value,
        input  pop_value, load_valid, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  enable, push, pop, push_value,
        output pop_value, load_valid, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_pointer.sv
// Saturating up/down depth counter for the call stack; empty/full decode
// straight from the registered count.
module stack_pointer #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             hold,
    output logic [PTR_W-1:0] depth,
    output logic             empty,
    output logic             full
);
    localparam logic [PTR_W-1:0] MAX = PTR_W'(DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (!hold) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (inc && !dec && depth != MAX)
                depth <= depth + PTR_W'(1);
            else if (dec && !inc && depth != '0)
                depth <= depth - PTR_W'(1);
        end
    end

    assign empty = (depth == '0);
    assign full  = (depth == MAX);
endmodule

// File: rtl/call_stack.sv
// Return-address LIFO feeding the PC load path (pop_value / load_valid).
// Define CALL_STACK_ERR_STICKY_EN to latch overflow/underflow until reset;
// otherwise each is a one-cycle pulse.
module call_stack
    import tau_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    call_stack_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    stack_op_t        op;
    logic [PTR_W-1:0] depth;
    logic             empty;
    logic             full;
    logic             inc;
    logic             dec;
    logic             hold;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_pop;
    logic             ovf_evt;
    logic             unf_evt;

    stack_pointer #(.DEPTH(DEPTH)) u_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (inc),
        .dec     (dec),
        .hold    (hold),
        .depth   (depth),
        .empty   (empty),
        .full    (full)
    );

    assign op      = bus.enable ? stk_decode(bus.push, bus.pop) : STK_NONE;
    assign top_idx = IDX_W'(depth - PTR_W'(1));

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        inc     = 1'b0;
        dec     = 1'b0;
        hold    = (op == STK_NONE);
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(depth);
        do_pop  = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        unique case (op)
            STK_PUSH: begin
                if (!full) begin
                    wr_en = 1'b1;
                    inc   = 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                end
            end
            STK_POP: begin
                if (!empty) begin
                    do_pop = 1'b1;
                    dec    = 1'b1;
                end else begin
                    unf_evt = 1'b1;
                end
            end
            STK_REPLACE: begin
                // Tail call: swap the top in place; on an empty stack it degrades to a push.
                if (!empty) begin
                    do_pop = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    wr_en   = 1'b1;
                    inc     = 1'b1;
                    unf_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: storage is not reset; only entries below depth are ever read.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_idx] <= bus.push_value;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.pop_value  <= '0;
            bus.load_valid <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.underflow  <= 1'b0;
        end else begin
            bus.load_valid <= do_pop;
            if (do_pop)
                bus.pop_value <= mem[top_idx];
`ifdef CALL_STACK_ERR_STICKY_EN
            bus.overflow  <= bus.overflow  | ovf_evt;
            bus.underflow <= bus.underflow | unf_evt;
`else
            bus.overflow  <= ovf_evt;
            bus.underflow <= unf_evt;
`endif
        end
    end

    assign bus.depth = depth;
    assign bus.empty = empty;
    assign bus.full  = full;
endmodule
